// File: rtl/immediate_pkg.sv
// Shared definitions for the immediate encoder: format codes, select-field layout,
// FIFO depth and the representability helper used when IMM_RANGE_CHECK_EN is defined.
package immediate_pkg;

    typedef enum logic [2:0] {
        FMT_U     = 3'd0,
        FMT_J     = 3'd1,
        FMT_I     = 3'd2,
        FMT_B     = 3'd3,
        FMT_S     = 3'd4,
        FMT_SHAMT = 3'd5,
        FMT_RSV6  = 3'd6,
        FMT_RSV7  = 3'd7
    } fmt_e;

    localparam int          UNSIGNED_BIT = 3;
    localparam logic [1:0]  FIFO_DEPTH   = 2'd2;

    // True when imm fits in 'width' bits (two's complement unless is_unsigned).
    function automatic logic imm_fits(input logic [31:0] imm, input logic [4:0] width,
                                      input logic is_unsigned);
        logic [31:0] hi;
        if (is_unsigned) begin
            hi = imm >> width;
            return (hi == 32'h0000_0000);
        end else begin
            hi = $signed(imm) >>> (width - 5'd1);
            return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
        end
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packing of an immediate into an instruction template.
// Range checking is compiled in only when IMM_RANGE_CHECK_EN is defined.
module imm_field_pack
    import immediate_pkg::*;
(
    input  logic [31:0] i_template,
    input  logic [31:0] i_imm,
    input  logic [3:0]  i_select,
    output logic [31:0] o_inst,
    output logic        o_error
);

    fmt_e        w_fmt;
    logic [31:0] w_mask;
    logic [31:0] w_bits;
    logic        w_rsv;
    logic        w_range_err;

    assign w_fmt = fmt_e'(i_select[2:0]);

    // Immediate bit positions of each format and the scattered IMM bits that fill them.
    always_comb begin
        w_mask = 32'h0000_0000;
        w_bits = 32'h0000_0000;
        w_rsv  = 1'b0;
        case (w_fmt)
            FMT_U: begin
                w_mask = 32'hFFFF_F000;
                w_bits = {i_imm[31:12], 12'h000};
            end
            FMT_J: begin
                w_mask = 32'hFFFF_F000;
                w_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'h000};
            end
            FMT_I: begin
                w_mask = 32'hFFF0_0000;
                w_bits = {i_imm[11:0], 20'h00000};
            end
            FMT_B: begin
                w_mask = 32'hFE00_0F80;
                w_bits = {i_imm[12], i_imm[10:5], 13'h0000, i_imm[4:1], i_imm[11], 7'h00};
            end
            FMT_S: begin
                w_mask = 32'hFE00_0F80;
                w_bits = {i_imm[11:5], 13'h0000, i_imm[4:0], 7'h00};
            end
            FMT_SHAMT: begin
                w_mask = 32'h01F0_0000;
                w_bits = {7'h00, i_imm[4:0], 20'h00000};
            end
            default: begin
                w_rsv = 1'b1;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic w_uns;
    assign w_uns = i_select[UNSIGNED_BIT];

    // Flags immediates that the chosen format cannot represent exactly.
    always_comb begin
        case (w_fmt)
            FMT_U:        w_range_err = (i_imm[11:0] != 12'h000);
            FMT_J:        w_range_err = i_imm[0] | ~imm_fits(i_imm, 5'd21, w_uns);
            FMT_B:        w_range_err = i_imm[0] | ~imm_fits(i_imm, 5'd13, w_uns);
            FMT_I, FMT_S: w_range_err = ~imm_fits(i_imm, 5'd12, w_uns);
            FMT_SHAMT:    w_range_err = (i_imm[31:5] != 27'h0000000);
            default:      w_range_err = 1'b0;
        endcase
    end
`else
    logic w_unused_sel;
    assign w_unused_sel = i_select[UNSIGNED_BIT];
    assign w_range_err  = 1'b0;
`endif

    assign o_inst  = (i_template & ~w_mask) | w_bits;
    assign o_error = w_rsv | w_range_err;

endmodule

// File: rtl/immediate_encoder.sv
// Immediate encoder: packs IMM into TEMPLATE and queues results in a 2-entry FIFO.
// Optional range checking via IMM_RANGE_CHECK_EN (see imm_field_pack).
module immediate_encoder
    import immediate_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] TEMPLATE,
    input  logic [31:0] IMM,
    input  logic [3:0]  SELECT,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_INST,
    output logic        OUT_ERROR,
    output logic [15:0] OUT_COUNT
);

    logic [31:0] w_pack_inst;
    logic        w_pack_err;

    imm_field_pack u_pack (
        .i_template (TEMPLATE),
        .i_imm      (IMM),
        .i_select   (SELECT),
        .o_inst     (w_pack_inst),
        .o_error    (w_pack_err)
    );

    // Head entry drives the outputs directly; tail is the second FIFO slot.
    logic        r_head_valid, r_tail_valid, r_in_ready;
    logic        r_head_err, r_tail_err;
    logic [31:0] r_head_inst, r_tail_inst;
    logic [15:0] r_count;

    logic        w_push, w_pop;
    logic        w_head_valid, w_tail_valid, w_head_err, w_tail_err;
    logic [31:0] w_head_inst, w_tail_inst;
    logic [1:0]  w_occ_next;

    assign w_push = IN_VALID & r_in_ready;
    assign w_pop  = r_head_valid & OUT_READY;

    // Next FIFO state: pop shifts tail into head, push fills the first free slot.
    always_comb begin
        w_head_valid = r_head_valid;
        w_head_inst  = r_head_inst;
        w_head_err   = r_head_err;
        w_tail_valid = r_tail_valid;
        w_tail_inst  = r_tail_inst;
        w_tail_err   = r_tail_err;
        if (w_pop) begin
            if (r_tail_valid) begin
                w_head_inst  = r_tail_inst;
                w_head_err   = r_tail_err;
                w_tail_valid = w_push;
                w_tail_inst  = w_pack_inst;
                w_tail_err   = w_pack_err;
            end else begin
                w_head_valid = w_push;
                w_head_inst  = w_pack_inst;
                w_head_err   = w_pack_err;
            end
        end else if (w_push) begin
            if (!r_head_valid) begin
                w_head_valid = 1'b1;
                w_head_inst  = w_pack_inst;
                w_head_err   = w_pack_err;
            end else begin
                w_tail_valid = 1'b1;
                w_tail_inst  = w_pack_inst;
                w_tail_err   = w_pack_err;
            end
        end else begin
            w_head_valid = r_head_valid;
        end
        w_occ_next = {1'b0, w_head_valid} + {1'b0, w_tail_valid};
    end

    // FIFO state, registered ready and handshake counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_head_valid <= 1'b0;
            r_head_inst  <= 32'h0000_0000;
            r_head_err   <= 1'b0;
            r_tail_valid <= 1'b0;
            r_tail_inst  <= 32'h0000_0000;
            r_tail_err   <= 1'b0;
            r_in_ready   <= 1'b0;
            r_count      <= 16'h0000;
        end else begin
            r_head_valid <= w_head_valid;
            r_head_inst  <= w_head_inst;
            r_head_err   <= w_head_err;
            r_tail_valid <= w_tail_valid;
            r_tail_inst  <= w_tail_inst;
            r_tail_err   <= w_tail_err;
            r_in_ready   <= (w_occ_next < FIFO_DEPTH);
            r_count      <= r_count + {15'h0000, w_pop};
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_head_valid;
    assign OUT_INST  = r_head_inst;
    assign OUT_ERROR = r_head_err;
    assign OUT_COUNT = r_count;

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed self-checking bench for immediate_encoder; expectations follow IMM_RANGE_CHECK_EN.
module tb_immediate_encoder;

    logic        CLK = 1'b0;
    logic        RESET, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OUT_ERROR;
    logic [31:0] TEMPLATE, IMM, OUT_INST;
    logic [3:0]  SELECT;
    logic [15:0] OUT_COUNT;
    logic [15:0] exp_count;
    int          total = 0;
    int          bad = 0;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] tmpl;
        logic [31:0] imm;
        logic [3:0]  sel;
        logic [31:0] inst;
        logic        err_plain;
        logic        err_chk;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV] = '{
        '{32'h0000_0093, 32'hFFFF_FFFF, 4'b0010, 32'hFFF0_0093, 1'b0, 1'b0},
        '{32'h0000_0063, 32'h0000_0008, 4'b0011, 32'h0000_0463, 1'b0, 1'b0},
        '{32'h0000_0063, 32'h0000_0003, 4'b0011, 32'h0000_0163, 1'b0, 1'b1},
        '{32'h0000_02B7, 32'h1234_5000, 4'b0000, 32'h1234_52B7, 1'b0, 1'b0},
        '{32'h0000_02B7, 32'h1234_5000, 4'b0110, 32'h0000_02B7, 1'b1, 1'b1},
        '{32'h0000_02B7, 32'h1234_5000, 4'b0111, 32'h0000_02B7, 1'b1, 1'b1},
        '{32'h0000_006F, 32'h0000_0800, 4'b0001, 32'h0010_006F, 1'b0, 1'b0},
        '{32'h0000_006F, 32'h0000_0002, 4'b0001, 32'h0020_006F, 1'b0, 1'b0},
        '{32'h0000_2023, 32'hFFFF_FFFF, 4'b0100, 32'hFE00_2FA3, 1'b0, 1'b0},
        '{32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, 32'h01FF_F07F, 1'b0, 1'b0},
        '{32'h0000_1013, 32'h0000_001F, 4'b0101, 32'h01F0_1013, 1'b0, 1'b0},
        '{32'h0000_1013, 32'h0000_0020, 4'b0101, 32'h0000_1013, 1'b0, 1'b1},
        '{32'h0000_0093, 32'h0000_0800, 4'b0010, 32'h8000_0093, 1'b0, 1'b1},
        '{32'h0000_0093, 32'h0000_0800, 4'b1010, 32'h8000_0093, 1'b0, 1'b0},
        '{32'h0000_0063, 32'hFFFF_FFF8, 4'b0011, 32'hFE00_0CE3, 1'b0, 1'b0},
        '{32'h0000_0063, 32'hFFFF_FFF8, 4'b1011, 32'hFE00_0CE3, 1'b0, 1'b1},
        '{32'h0000_02B7, 32'h0000_0001, 4'b0000, 32'h0000_02B7, 1'b0, 1'b1},
        '{32'h0000_006F, 32'h0010_0000, 4'b0001, 32'h8000_006F, 1'b0, 1'b1},
        '{32'h0000_006F, 32'h0010_0000, 4'b1001, 32'h8000_006F, 1'b0, 1'b0},
        '{32'hFFFF_FFFF, 32'h0000_0000, 4'b0010, 32'h000F_FFFF, 1'b0, 1'b0}
    };

    immediate_encoder dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .TEMPLATE  (TEMPLATE),
        .IMM       (IMM),
        .SELECT    (SELECT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_INST  (OUT_INST),
        .OUT_ERROR (OUT_ERROR),
        .OUT_COUNT (OUT_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] t, input logic [31:0] i, input logic [3:0] s);
        TEMPLATE = t;
        IMM      = i;
        SELECT   = s;
        IN_VALID = 1'b1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        IN_VALID = 1'b0;
        step();
        RESET = 1'b0;
        step();
        exp_count = 16'h0000;
    endtask

    task automatic test_reset();
        RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        TEMPLATE = 32'h0; IMM = 32'h0; SELECT = 4'h0;
        step(); step();
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", IN_READY); end
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", OUT_VALID); end
        total++; if (OUT_INST !== 32'h0) begin bad++; $display("FAIL rst_out_inst got=%h exp=0", OUT_INST); end
        total++; if (OUT_ERROR !== 1'b0) begin bad++; $display("FAIL rst_out_error got=%b exp=0", OUT_ERROR); end
        total++; if (OUT_COUNT !== 16'h0) begin bad++; $display("FAIL rst_count got=%h exp=0", OUT_COUNT); end
        RESET = 1'b0;
        step();
        exp_count = 16'h0000;
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", IN_READY); end
    endtask

    task automatic test_packing();
        logic exp_err;
        OUT_READY = 1'b1;
        for (int i = 0; i < NV; i++) begin
            exp_err = CHK ? vecs[i].err_chk : vecs[i].err_plain;
            drive(vecs[i].tmpl, vecs[i].imm, vecs[i].sel);
            total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL pack_pre_valid[%0d] got=%b exp=0", i, OUT_VALID); end
            step();
            IN_VALID = 1'b0;
            total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL pack_valid[%0d] got=%b exp=1", i, OUT_VALID); end
            total++; if (OUT_INST !== vecs[i].inst) begin bad++; $display("FAIL pack_inst[%0d] got=%h exp=%h", i, OUT_INST, vecs[i].inst); end
            total++; if (OUT_ERROR !== exp_err) begin bad++; $display("FAIL pack_error[%0d] got=%b exp=%b", i, OUT_ERROR, exp_err); end
            step();
            exp_count = exp_count + 16'h0001;
            total++; if (OUT_COUNT !== exp_count) begin bad++; $display("FAIL pack_count[%0d] got=%h exp=%h", i, OUT_COUNT, exp_count); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        OUT_READY = 1'b0;
        drive(32'h0000_0037, 32'h1111_1000, 4'b0000);
        step();
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b exp=1", IN_READY); end
        drive(32'h0000_0037, 32'h2222_2000, 4'b0000);
        step();
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL b2b_ready2 got=%b exp=0", IN_READY); end
        drive(32'h0000_0037, 32'h3333_3000, 4'b0000);
        step();
        IN_VALID = 1'b0;
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL b2b_ready3 got=%b exp=0", IN_READY); end
        total++; if (OUT_VALID !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", OUT_VALID); end
        total++; if (OUT_INST !== 32'h1111_1037) begin bad++; $display("FAIL b2b_head got=%h exp=11111037", OUT_INST); end
        step();
        total++; if (OUT_INST !== 32'h1111_1037) begin bad++; $display("FAIL b2b_hold got=%h exp=11111037", OUT_INST); end
        OUT_READY = 1'b1;
        step();
        total++; if (OUT_INST !== 32'h2222_2037) begin bad++; $display("FAIL b2b_second got=%h exp=22222037", OUT_INST); end
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL b2b_ready4 got=%b exp=1", IN_READY); end
        step();
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", OUT_VALID); end
        total++; if (OUT_COUNT !== 16'h0002) begin bad++; $display("FAIL b2b_count got=%h exp=0002", OUT_COUNT); end
        exp_count = 16'h0002;
    endtask

    task automatic test_stream();
        OUT_READY = 1'b1;
        drive(32'h0000_0037, 32'h4444_4000, 4'b0000);
        step();
        drive(32'h0000_0037, 32'h5555_5000, 4'b0000);
        step();
        IN_VALID = 1'b0;
        total++; if (OUT_INST !== 32'h5555_5037) begin bad++; $display("FAIL stream_inst got=%h exp=55555037", OUT_INST); end
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL stream_ready got=%b exp=1", IN_READY); end
        step();
        exp_count = exp_count + 16'h0002;
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL stream_drained got=%b exp=0", OUT_VALID); end
        total++; if (OUT_COUNT !== exp_count) begin bad++; $display("FAIL stream_count got=%h exp=%h", OUT_COUNT, exp_count); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        OUT_READY = 1'b1;
        drive(32'h0000_0013, 32'h0000_0001, 4'b0010);
        repeat (65535) step();
        IN_VALID = 1'b0;
        step();
        total++; if (OUT_COUNT !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", OUT_COUNT); end
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        step();
        total++; if (OUT_COUNT !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", OUT_COUNT); end
        OUT_READY = 1'b0;
        IN_VALID = 1'b1;
        step(); step();
        IN_VALID = 1'b0;
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL wrap_full got=%b exp=0", IN_READY); end
        RESET = 1'b1;
        step();
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", OUT_VALID); end
        total++; if (OUT_INST !== 32'h0) begin bad++; $display("FAIL midrst_inst got=%h exp=0", OUT_INST); end
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", IN_READY); end
        RESET = 1'b0;
        step();
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL midrst_ready_after got=%b exp=1", IN_READY); end
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("FAIL midrst_discard got=%b exp=0", OUT_VALID); end
    endtask

    initial begin
        test_reset();
        test_packing();
        test_back_to_back();
        test_stream();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/immediate_encoder.md
IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

Interface
REQ-001 SHALL have ports: CLK  in  1  rising-edge clock.
REQ-002 SHALL have ports: RESET  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: IN_VALID  in  1  request valid.
REQ-004 SHALL have ports: IN_READY  out  1  encoder can accept a request.
REQ-005 SHALL have ports: TEMPLATE  in  32  instruction carrying opcode/rd/rs/funct (immediate bits don't-care).
REQ-006 SHALL have ports: IMM  in  32  immediate value to pack.
REQ-007 SHALL have ports: SELECT  in  4  [2:0] format code, [3] unsigned flag.
REQ-008 SHALL have ports: OUT_VALID  out  1; OUT_READY  in  1; OUT_INST  out  32; OUT_ERROR  out  1; OUT_COUNT  out  16 (completed output handshakes).

Function
REQ-009 SHALL clear the format's immediate bit positions in TEMPLATE, then insert the packed IMM bits.
REQ-010 SHALL pack SELECT[2:0]=000 (U) as INST[31:12]=IMM[31:12].
REQ-011 SHALL pack 001 (J) as [31]=IMM[20], [30:21]=IMM[10:1], [20]=IMM[11], [19:12]=IMM[19:12].
REQ-012 SHALL pack 010 (I) as [31:20]=IMM[11:0].
REQ-013 SHALL pack 011 (B) as [31]=IMM[12], [30:25]=IMM[10:5], [11:8]=IMM[4:1], [7]=IMM[11].
REQ-014 SHALL pack 100 (S) as [31:25]=IMM[11:5], [11:7]=IMM[4:0].
REQ-015 SHALL pack 101 (shamt) as [24:20]=IMM[4:0].
REQ-016 SHALL, for SELECT[2:0]=110/111, pass TEMPLATE unchanged with OUT_ERROR=1, regardless of the configuration macro.
REQ-017 SHALL accept a request on IN_VALID&IN_READY and present the result, valid, the following cycle (latency 1).
REQ-018 SHALL buffer results in a 2-entry in-order FIFO; IN_READY = (occupancy<2), driven from registered state only, with no combinational path from OUT_READY.
REQ-019 SHALL hold OUT_INST/OUT_ERROR stable while OUT_VALID=1 and OUT_READY=0.
REQ-020 SHALL leave occupancy unchanged when accept and output handshakes occur in the same cycle.
REQ-021 SHALL increment OUT_COUNT on each OUT_VALID&OUT_READY, wrapping from 16'hFFFF to 0.

Reset
REQ-022 SHALL, while RESET=1 at a CLK edge, set occupancy=0, OUT_VALID=0, OUT_INST=0, OUT_ERROR=0, OUT_COUNT=0, IN_READY=0.
REQ-023 SHALL drive IN_READY=1 in the first cycle after RESET deasserts.
REQ-024 SHALL discard in-flight and buffered entries on a reset asserted mid-operation.

Configuration
REQ-025 SHALL honour macro IMM_RANGE_CHECK_EN; when defined, OUT_ERROR=1 if IMM is not exactly representable:
- U: IMM[11:0]!=0.
- J/B: IMM[0]!=0, or IMM is outside 21-/13-bit signed range (unsigned range when SELECT[3]=1).
- I/S: IMM is outside 12-bit signed range (unsigned range when SELECT[3]=1).
- shamt: IMM[31:5]!=0.
REQ-026 SHALL, without IMM_RANGE_CHECK_EN, perform no range checks; OUT_ERROR is then set only per REQ-016 and is 0 for all valid formats; packing is unchanged.

Structure
REQ-027 SHALL place format codes (FMT_U..FMT_SHAMT), the unsigned-flag bit index and FIFO depth in shared package immediate_pkg.
REQ-028 SHALL implement packing and range checking in combinational sub-module imm_field_pack; the FIFO and counter stay in immediate_encoder.

Verification
REQ-029 SHALL cover: TEMPLATE=0x00000093, IMM=0xFFFFFFFF, SELECT=4'b0010 -> OUT_INST=0xFFF00093, OUT_ERROR=0, one cycle later.
REQ-030 SHALL cover: TEMPLATE=0x00000063, IMM=8, SELECT=4'b0011 -> 0x00000463; IMM=3 with IMM_RANGE_CHECK_EN defined -> OUT_ERROR=1.
REQ-031 SHALL cover: TEMPLATE=0x000002B7, IMM=0x12345000, SELECT=4'b0000 -> 0x123452B7; SELECT=4'b0110 -> 0x000002B7 with OUT_ERROR=1.
REQ-032 SHALL cover: OUT_READY=0 with 3 back-to-back requests -> 2 accepted, IN_READY=0, outputs held; OUT_READY=1 -> outputs drain in order, OUT_COUNT=2.
REQ-033 SHALL cover: OUT_COUNT preloaded to 0xFFFF by 65535 handshakes, one more handshake -> 0x0000; RESET with 2 buffered entries -> OUT_VALID=0 next cycle.
